// File: rtl/clk_gen_pkg.sv
// Shared types for the programmable derived-clock generator.
// Holds the FSM encoding, the config bundle and the zero-count clamp.
package clk_gen_pkg;

  localparam int unsigned CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PHASE = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } state_e;

  typedef struct packed {
    logic [CNT_W_DEF-1:0] phase;
    logic [CNT_W_DEF-1:0] ton;
    logic [CNT_W_DEF-1:0] toff;
  } cfg_t;

  function automatic logic [CNT_W_DEF-1:0] clamp1(
    input logic [CNT_W_DEF-1:0] v
  );
    return (v == '0) ? CNT_W_DEF'(1) : v;
  endfunction

endpackage

// File: rtl/clk_gen_cfg_shadow.sv
// Active/shadow config registers with valid/ready intake.
// Shadow contents move to active only at a period boundary or in IDLE.
module clk_gen_cfg_shadow
  import clk_gen_pkg::*;
#(
  parameter cfg_t RST_CFG = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic idle_i,
  input  logic boundary_i,
  input  logic cfg_valid_i,
  input  cfg_t cfg_i,
  output logic cfg_ready_o,
  output logic cfg_pending_o,
  output cfg_t next_o
);

  cfg_t active_q, active_d;
  cfg_t shadow_q, shadow_d;
  logic pending_q, pending_d;
  logic acc;

  assign cfg_ready_o   = idle_i | ~pending_q;
  assign acc           = cfg_valid_i & cfg_ready_o;
  assign cfg_pending_o = pending_q;
  assign next_o        = active_d;

  always_comb begin
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (idle_i) begin
      // a word left over from an aborted run still takes effect
      if (acc) active_d = cfg_i;
      else if (pending_q) active_d = shadow_q;
      pending_d = 1'b0;
    end else begin
      if (boundary_i && pending_q) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end
      if (acc) begin
        shadow_d  = cfg_i;
        pending_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q  <= RST_CFG;
      shadow_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: rtl/clk_gen_ctrl.sv
// Derived-clock generator: phase / high / low down-counter FSM.
// All outputs are registered from next-state so gen_clk is glitch-free.
module clk_gen_ctrl
  import clk_gen_pkg::*;
#(
  parameter int unsigned CNT_W     = CNT_W_DEF,
  parameter int unsigned RST_PHASE = 0,
  parameter int unsigned RST_TON   = 5,
  parameter int unsigned RST_TOFF  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_phase,
  input  logic [CNT_W-1:0] cfg_ton,
  input  logic [CNT_W-1:0] cfg_toff,
  output logic             gen_clk,
  output logic             busy,
  output logic             period_done,
  output logic             cfg_pending
);

  localparam cfg_t RST_CFG = '{
    phase: CNT_W_DEF'(RST_PHASE),
    ton:   CNT_W_DEF'(RST_TON),
    toff:  CNT_W_DEF'(RST_TOFF)
  };

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gen_q, busy_q, pd_q;
  logic             boundary;
  cfg_t             cfg_in, cfg_nxt;

  assign cfg_in = '{
    phase: CNT_W_DEF'(cfg_phase),
    ton:   CNT_W_DEF'(cfg_ton),
    toff:  CNT_W_DEF'(cfg_toff)
  };

  assign boundary = (state_q == LOW) && (cnt_q == '0);

  clk_gen_cfg_shadow #(
    .RST_CFG(RST_CFG)
  ) u_shadow (
    .clk          (clk),
    .rst_n        (rst_n),
    .idle_i       (state_q == IDLE),
    .boundary_i   (boundary),
    .cfg_valid_i  (cfg_valid),
    .cfg_i        (cfg_in),
    .cfg_ready_o  (cfg_ready),
    .cfg_pending_o(cfg_pending),
    .next_o       (cfg_nxt)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (en) begin
          if (cfg_nxt.phase == '0) begin
            state_d = HIGH;
            cnt_d   = CNT_W'(clamp1(cfg_nxt.ton) - 1'b1);
          end else begin
            state_d = PHASE;
            cnt_d   = CNT_W'(cfg_nxt.phase - 1'b1);
          end
        end
      end
      PHASE: begin
        if (!en) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = HIGH;
          cnt_d   = CNT_W'(clamp1(cfg_nxt.ton) - 1'b1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HIGH: begin
        if (cnt_q == '0) begin
          state_d = LOW;
          cnt_d   = CNT_W'(clamp1(cfg_nxt.toff) - 1'b1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      LOW: begin
        // phase is applied only when leaving IDLE
        if (cnt_q == '0) begin
          if (en) begin
            state_d = HIGH;
            cnt_d   = CNT_W'(clamp1(cfg_nxt.ton) - 1'b1);
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gen_q   <= 1'b0;
      busy_q  <= 1'b0;
      pd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gen_q   <= (state_d == HIGH);
      busy_q  <= (state_d != IDLE);
      pd_q    <= (state_d == LOW) && (cnt_d == '0);
    end
  end

  assign gen_clk     = gen_q;
  assign busy        = busy_q;
  assign period_done = pd_q;

endmodule

// File: tb/tb_clk_gen_ctrl.sv
// Scoreboard bench for clk_gen_ctrl: expected output vectors are
// queued per edge and compared by an independent monitor.
module tb_clk_gen_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [7:0] cfg_phase = '0;
  logic [7:0] cfg_ton = '0;
  logic [7:0] cfg_toff = '0;
  logic       gen_clk, busy, period_done, cfg_pending;

  clk_gen_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_phase  (cfg_phase),
    .cfg_ton    (cfg_ton),
    .cfg_toff   (cfg_toff),
    .gen_clk    (gen_clk),
    .busy       (busy),
    .period_done(period_done),
    .cfg_pending(cfg_pending)
  );

  always #5 clk = ~clk;

  // vector order: {gen_clk, busy, period_done, cfg_pending, cfg_ready}
  typedef struct {
    int         t;
    bit         as;
    logic [4:0] v;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   edge_n = 0;

  // edges k.. for the phase / reconfig / stop sequence
  localparam logic [4:0] SEQ [0:20] = '{
    5'b01001, 5'b01001, 5'b11001, 5'b11001, 5'b11001,
    5'b01001, 5'b01101, 5'b11001, 5'b11010, 5'b11010,
    5'b01010, 5'b01110, 5'b11001, 5'b01110, 5'b11001,
    5'b11001, 5'b11001, 5'b01001, 5'b01101, 5'b00001,
    5'b00001
  };

  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic logic [4:0] act();
    return {gen_clk, busy, period_done, cfg_pending, cfg_ready};
  endfunction

  task automatic cmp(input exp_t e);
    logic [4:0] a;
    a = act();
    checks++;
    if (a !== e.v) begin
      failures++;
      $display("FAIL %s edge=%0d got=%b exp=%b (gen,busy,pd,pend,rdy)",
               e.nm, e.t, a, e.v);
    end
  endtask

  task automatic push(input int t, input bit as,
                      input logic [4:0] v, input string nm);
    exp_t e;
    e.t  = t;
    e.as = as;
    e.v  = v;
    e.nm = nm;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && !q[0].as && q[0].t <= edge_n) begin
      e = q.pop_front();
      if (e.t < edge_n) begin
        checks++;
        failures++;
        $display("FAIL %s missed edge=%0d now=%0d", e.nm, e.t, edge_n);
      end else begin
        cmp(e);
      end
    end
  end

  always @(negedge rst_n) begin
    #1;
    if (q.size() > 0 && q[0].as) cmp(q.pop_front());
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_cfg(input logic [7:0] p, input logic [7:0] on,
                         input logic [7:0] off);
    cfg_phase = p;
    cfg_ton   = on;
    cfg_toff  = off;
  endtask

  initial begin
    int k;
    int j;
    int m;
    int r;
    push(1, 1'b0, 5'b00001, "reset_state");
    push(2, 1'b0, 5'b00001, "reset_state");
    step(3);
    rst_n = 1'b1;

    // reset config 0/5/5: divide by ten
    en = 1'b1;
    k = edge_n + 1;
    for (int i = 0; i < 20; i++)
      push(k + i, 1'b0,
           {((i % 10) < 5), 1'b1, ((i % 10) == 9), 1'b0, 1'b1},
           "div10");
    push(k + 20, 1'b0, 5'b00001, "div10_stop");
    step(20);
    en = 1'b0;
    step(2);

    // phase 2, ton 3, toff 2; then reconfig and stop
    set_cfg(8'd2, 8'd3, 8'd2);
    cfg_valid = 1'b1;
    push(edge_n + 1, 1'b0, 5'b00001, "idle_cfg_accept");
    step(1);
    cfg_valid = 1'b0;
    en = 1'b1;
    k = edge_n + 1;
    for (int i = 0; i < 21; i++)
      push(k + i, 1'b0, SEQ[i], "phase_reconfig_stop");
    step(8);
    set_cfg(8'd0, 8'd1, 8'd1);
    cfg_valid = 1'b1;
    step(1);
    set_cfg(8'd0, 8'd3, 8'd2);
    step(5);
    cfg_valid = 1'b0;
    step(2);
    en = 1'b0;
    step(6);

    // abort during phase 5
    set_cfg(8'd5, 8'd0, 8'd1);
    cfg_valid = 1'b1;
    push(edge_n + 1, 1'b0, 5'b00001, "idle_cfg_accept2");
    step(1);
    cfg_valid = 1'b0;
    en = 1'b1;
    j = edge_n + 1;
    push(j,     1'b0, 5'b01001, "phase_abort_run");
    push(j + 1, 1'b0, 5'b01001, "phase_abort_run");
    push(j + 2, 1'b0, 5'b00001, "phase_abort_idle");
    push(j + 3, 1'b0, 5'b00001, "phase_abort_idle");
    step(2);
    en = 1'b0;
    step(3);

    // ton 0 clamps to 1
    set_cfg(8'd0, 8'd0, 8'd2);
    cfg_valid = 1'b1;
    push(edge_n + 1, 1'b0, 5'b00001, "idle_cfg_accept3");
    step(1);
    cfg_valid = 1'b0;
    en = 1'b1;
    m = edge_n + 1;
    push(m,     1'b0, 5'b11001, "ton0_high");
    push(m + 1, 1'b0, 5'b01001, "ton0_low");
    push(m + 2, 1'b0, 5'b01101, "ton0_done");
    push(m + 3, 1'b0, 5'b11010, "accept_at_boundary");
    step(3);
    set_cfg(8'd0, 8'd4, 8'd4);
    cfg_valid = 1'b1;
    step(1);
    cfg_valid = 1'b0;

    // async reset mid-HIGH with a pending word
    push(0, 1'b1, 5'b00001, "async_reset");
    push(m + 4, 1'b0, 5'b00001, "in_reset");
    push(m + 5, 1'b0, 5'b00001, "in_reset");
    #2;
    rst_n = 1'b0;
    step(2);
    r = edge_n;
    for (int i = 1; i <= 11; i++)
      push(r + i, 1'b0,
           {(((i - 1) % 10) < 5), 1'b1, (i == 10), 1'b0, 1'b1},
           "post_reset_defaults");
    rst_n = 1'b1;
    step(12);
    en = 1'b0;
    step(12);

    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      failures++;
      $display("FAIL %s unchecked edge=%0d", e.nm, e.t);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
